// File: rtl/spmv_pkg.sv
// Shared types for the SpMV result path.
//   collector_state_t : spmv_result_collector FSM states.
//     ACCUM - lanes are accepted and summed into the row register file
//     DRAIN - the row vector streams out in index order; lanes are held off
package spmv_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } collector_state_t;

endpackage

// File: rtl/spmv_lane_match_sum.sv
// Masked multi-lane adder for one row entry.
// This block adds every enabled lane whose id equals entry_id. The lanes are
// zero-extended into a sum that is wider than the accumulator. Any bit above
// ACC_WIDTH means the lane sum alone has already wrapped, and carry reports it.
// Ports:
//   entry_id  in   ID_WIDTH            row index this instance serves
//   lane_en   in   NETWORK_WIDTH       lanes whose beat is accepted this cycle
//   in_id     in   ID_WIDTH[NW]        per-lane row id
//   in_val    in   IN_WIDTH[NW]        per-lane unsigned partial sum
//   sum       out  ACC_WIDTH           matched-lane sum modulo 2**ACC_WIDTH
//   carry     out  1                   matched-lane sum exceeded ACC_WIDTH bits
module spmv_lane_match_sum #(
    parameter int NETWORK_WIDTH = 6,
    parameter int ID_WIDTH      = 5,
    parameter int IN_WIDTH      = 37,
    parameter int ACC_WIDTH     = 48
) (
    input  logic [ID_WIDTH-1:0]      entry_id,
    input  logic [NETWORK_WIDTH-1:0] lane_en,
    input  logic [ID_WIDTH-1:0]      in_id  [NETWORK_WIDTH],
    input  logic [IN_WIDTH-1:0]      in_val [NETWORK_WIDTH],
    output logic [ACC_WIDTH-1:0]     sum,
    output logic                     carry
);

    localparam int SUM_W = ACC_WIDTH + $clog2(NETWORK_WIDTH + 1);

    logic [SUM_W-1:0] total_s;

    // Add every accepted lane that targets this entry.
    always_comb begin
        total_s = '0;
        for (int i = 0; i < NETWORK_WIDTH; i++) begin
            if (lane_en[i] && (in_id[i] == entry_id)) begin
                total_s = total_s + SUM_W'(in_val[i]);
            end else begin
                total_s = total_s;
            end
        end
        sum   = total_s[ACC_WIDTH-1:0];
        carry = |total_s[SUM_W-1:ACC_WIDTH];
    end

endmodule

// File: rtl/spmv_result_collector.sv
// Result collector at the output of the SpMV reduction network.
// In ACCUM, each cycle accepts up to NETWORK_WIDTH (id, value) beats and adds
// them into a register file of 2**ID_WIDTH row accumulators. A flush pulse
// switches to DRAIN. In DRAIN, the rows stream out in index order on a
// valid/ready interface, and each row is cleared when its beat is accepted.
// All outputs are registered.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_id/in_val per-lane input beats
//   in_ready              per-lane ready (all bits equal; low while draining)
//   flush                 start a drain (ignored while draining)
//   busy                  high while draining
//   res_valid/res_ready   result stream handshake
//   res_idx/res_val       row index and accumulated value
//   res_last              marks row DEPTH-1
//   overflow              sticky accumulation carry-out flag
module spmv_result_collector
    import spmv_pkg::*;
#(
    parameter int NETWORK_WIDTH = 6,
    parameter int ID_WIDTH      = 5,
    parameter int IN_WIDTH      = 37,
    parameter int ACC_WIDTH     = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NETWORK_WIDTH-1:0] in_valid,
    input  logic [ID_WIDTH-1:0]      in_id  [NETWORK_WIDTH],
    input  logic [IN_WIDTH-1:0]      in_val [NETWORK_WIDTH],
    output logic [NETWORK_WIDTH-1:0] in_ready,
    input  logic                     flush,
    output logic                     busy,
    output logic                     res_valid,
    output logic [ID_WIDTH-1:0]      res_idx,
    output logic [ACC_WIDTH-1:0]     res_val,
    output logic                     res_last,
    input  logic                     res_ready,
    output logic                     overflow
);

    localparam int DEPTH = 2 ** ID_WIDTH;
    localparam logic [ID_WIDTH-1:0] LAST_IDX = {ID_WIDTH{1'b1}};

    collector_state_t           state_r;
    logic [ACC_WIDTH-1:0]       acc_r [DEPTH];
    logic [ID_WIDTH-1:0]        ptr_r;
    logic [NETWORK_WIDTH-1:0]   in_ready_r;
    logic                       busy_r;
    logic                       res_valid_r;
    logic [ID_WIDTH-1:0]        res_idx_r;
    logic [ACC_WIDTH-1:0]       res_val_r;
    logic                       res_last_r;
    logic                       overflow_r;

    logic [NETWORK_WIDTH-1:0]   lane_en_s;
    logic [ACC_WIDTH-1:0]       lane_sum_s [DEPTH];
    logic [DEPTH-1:0]           lane_carry_s;
    logic [DEPTH-1:0]           add_carry_s;
    logic [ACC_WIDTH-1:0]       acc_nxt_s [DEPTH];
    logic                       any_carry_s;
    logic                       handshake_s;
    logic [ID_WIDTH-1:0]        ptr_nxt_s;

    // Lanes are accepted only while accumulating.
    always_comb begin
        if (state_r == ACCUM) begin
            lane_en_s = in_valid;
        end else begin
            lane_en_s = '0;
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        spmv_lane_match_sum #(
            .NETWORK_WIDTH (NETWORK_WIDTH),
            .ID_WIDTH      (ID_WIDTH),
            .IN_WIDTH      (IN_WIDTH),
            .ACC_WIDTH     (ACC_WIDTH)
        ) u_match (
            .entry_id (ID_WIDTH'(e)),
            .lane_en  (lane_en_s),
            .in_id    (in_id),
            .in_val   (in_val),
            .sum      (lane_sum_s[e]),
            .carry    (lane_carry_s[e])
        );

        // The extra top bit catches the carry out of the accumulator add.
        assign {add_carry_s[e], acc_nxt_s[e]} = {1'b0, acc_r[e]} + {1'b0, lane_sum_s[e]};
    end

    // Drain handshake, next pointer (wraps after the last row), and overall carry.
    always_comb begin
        handshake_s = (state_r == DRAIN) && res_valid_r && res_ready;
        ptr_nxt_s   = ptr_r + 1'b1;
        any_carry_s = |(lane_carry_s | add_carry_s);
    end

    // Collector FSM, register file and registered result stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            for (int e = 0; e < DEPTH; e++) begin
                acc_r[e] <= '0;
            end
            ptr_r       <= '0;
            in_ready_r  <= '1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_idx_r   <= '0;
            res_val_r   <= '0;
            res_last_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    for (int e = 0; e < DEPTH; e++) begin
                        acc_r[e] <= acc_nxt_s[e];
                    end
                    if (any_carry_s) begin
                        overflow_r <= 1'b1;
                    end else begin
                        overflow_r <= overflow_r;
                    end
                    if (flush) begin
                        // Row 0 is loaded from the post-update value, so beats
                        // that arrive with the flush are included.
                        state_r     <= DRAIN;
                        ptr_r       <= '0;
                        in_ready_r  <= '0;
                        busy_r      <= 1'b1;
                        res_valid_r <= 1'b1;
                        res_idx_r   <= '0;
                        res_val_r   <= acc_nxt_s[0];
                        res_last_r  <= (LAST_IDX == '0);
                    end else begin
                        state_r     <= ACCUM;
                    end
                end
                DRAIN: begin
                    if (handshake_s) begin
                        acc_r[ptr_r] <= '0;
                        ptr_r        <= ptr_nxt_s;
                        if (res_last_r) begin
                            state_r     <= ACCUM;
                            in_ready_r  <= '1;
                            busy_r      <= 1'b0;
                            res_valid_r <= 1'b0;
                            res_idx_r   <= '0;
                            res_val_r   <= '0;
                            res_last_r  <= 1'b0;
                        end else begin
                            res_idx_r   <= ptr_nxt_s;
                            res_val_r   <= acc_r[ptr_nxt_s];
                            res_last_r  <= (ptr_nxt_s == LAST_IDX);
                        end
                    end else begin
                        // Stalled: every output holds its value.
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign res_idx   = res_idx_r;
    assign res_val   = res_val_r;
    assign res_last  = res_last_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_spmv_result_collector.sv
// Directed self-checking bench for spmv_result_collector.
module tb_spmv_result_collector;

    logic        clk;
    logic        rst_n;
    logic [5:0]  in_valid;
    logic [4:0]  in_id  [6];
    logic [36:0] in_val [6];
    logic [5:0]  in_ready;
    logic        flush;
    logic        busy;
    logic        res_valid;
    logic [4:0]  res_idx;
    logic [47:0] res_val;
    logic        res_last;
    logic        res_ready;
    logic        overflow;

    logic [47:0] model_acc [32];
    logic [47:0] got [32];
    int          errors;
    int          checks;

    spmv_result_collector u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_id     (in_id),
        .in_val    (in_val),
        .in_ready  (in_ready),
        .flush     (flush),
        .busy      (busy),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_val   (res_val),
        .res_last  (res_last),
        .res_ready (res_ready),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        in_valid = 6'h00;
        for (int i = 0; i < 6; i++) begin
            in_id[i]  = 5'd0;
            in_val[i] = 37'd0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 6; i++) begin
            if (in_valid[i]) begin
                model_acc[in_id[i]] = model_acc[in_id[i]] + 48'(in_val[i]);
            end
        end
    endtask

    task automatic accept();
        model_update();
        step();
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"},  64'(in_ready),  64'h3F);
        check_eq({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check_eq({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // Flush with whatever lanes are driven now (the caller updates the model), then drain all rows.
    task automatic drain(input bit stall);
        int   hs;
        int   cyc;
        logic rr;
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_lanes();
        hs  = 0;
        cyc = 0;
        while (hs < 32 && cyc < 200) begin
            rr = stall ? ((cyc % 3) == 0) : 1'b1;
            res_ready = rr;
            check_eq("drain_res_valid", 64'(res_valid), 64'd1);
            check_eq("drain_busy",      64'(busy),      64'd1);
            check_eq("drain_in_ready",  64'(in_ready),  64'd0);
            check_eq("drain_res_idx",   64'(res_idx),   64'(hs));
            check_eq("drain_res_val",   64'(res_val),   64'(model_acc[hs]));
            check_eq("drain_res_last",  64'(res_last),  64'(hs == 31));
            if (rr) begin
                got[hs] = res_val;
                model_acc[hs] = 48'd0;
                hs++;
            end
            step();
            cyc++;
        end
        res_ready = 1'b0;
        check_eq("drain_handshakes", 64'(hs), 64'd32);
        check_idle("post_drain");
    endtask

    initial begin
        logic [47:0] before_row2;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        res_ready = 1'b0;
        clear_lanes();
        for (int i = 0; i < 32; i++) begin
            model_acc[i] = 48'd0;
            got[i]       = 48'd0;
        end

        // 1: reset and idle, then drain an empty vector
        step();
        step();
        check_eq("rst_res_idx",  64'(res_idx),  64'd0);
        check_eq("rst_res_val",  64'(res_val),  64'd0);
        check_eq("rst_res_last", 64'(res_last), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_idle("rst");
        rst_n = 1'b1;
        step();
        check_idle("idle");
        drain(1'b0);
        check_eq("empty_row31", 64'(got[31]), 64'd0);

        // 2: single lane, two beats into row 3
        in_valid = 6'h01; in_id[0] = 5'd3; in_val[0] = 37'd10;
        accept();
        in_val[0] = 37'd5;
        accept();
        clear_lanes();
        step();
        drain(1'b0);
        check_eq("single_row3", 64'(got[3]), 64'd15);
        check_eq("single_row4", 64'(got[4]), 64'd0);

        // 3: all lanes hit row 7, then distinct rows 10..15
        in_valid = 6'h3F;
        for (int i = 0; i < 6; i++) begin
            in_id[i]  = 5'd7;
            in_val[i] = 37'(i + 1);
        end
        accept();
        for (int i = 0; i < 6; i++) begin
            in_id[i]  = 5'(10 + i);
            in_val[i] = 37'(100 + i);
        end
        accept();
        // 4: a beat arrives in the same cycle as the flush
        clear_lanes();
        in_valid = 6'h01; in_id[0] = 5'd0; in_val[0] = 37'd9;
        model_update();
        drain(1'b0);
        check_eq("collide_row7", 64'(got[7]),  64'd21);
        check_eq("distinct_r10", 64'(got[10]), 64'd100);
        check_eq("distinct_r15", 64'(got[15]), 64'd105);
        check_eq("flush_beat_r0", 64'(got[0]), 64'd9);

        // 5: backpressure drain, then a second drain returns zeros
        in_valid = 6'h03;
        in_id[0] = 5'd1;  in_val[0] = 37'd77;
        in_id[1] = 5'd30; in_val[1] = 37'd123456;
        accept();
        clear_lanes();
        drain(1'b1);
        check_eq("bp_row1",  64'(got[1]),  64'd77);
        check_eq("bp_row30", 64'(got[30]), 64'd123456);
        drain(1'b0);
        check_eq("second_row1",  64'(got[1]),  64'd0);
        check_eq("second_row30", 64'(got[30]), 64'd0);

        // 6: bring row 2 to 2**48-1 (2048 max beats + 2047), then add 1
        in_valid = 6'h3F;
        for (int i = 0; i < 6; i++) begin
            in_id[i]  = 5'd2;
            in_val[i] = {37{1'b1}};
        end
        for (int c = 0; c < 341; c++) begin
            accept();
        end
        in_valid  = 6'h07;
        in_val[2] = 37'd2047;
        accept();
        before_row2 = model_acc[2];
        check_eq("ovf_model_full", 64'(before_row2), 64'hFFFF_FFFF_FFFF);
        check_eq("ovf_not_yet", 64'(overflow), 64'd0);
        clear_lanes();
        in_valid = 6'h01; in_id[0] = 5'd2; in_val[0] = 37'd1;
        accept();
        clear_lanes();
        check_eq("ovf_set", 64'(overflow), 64'd1);
        drain(1'b0);
        check_eq("ovf_row2", 64'(got[2]), 64'd0);
        check_eq("ovf_sticky", 64'(overflow), 64'd1);

        // reset in the middle of a drain
        flush = 1'b1;
        step();
        flush = 1'b0;
        res_ready = 1'b1;
        step();
        step();
        check_eq("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_res_idx",  64'(res_idx),  64'd0);
        check_eq("mid_rst_res_val",  64'(res_val),  64'd0);
        check_eq("mid_rst_res_last", 64'(res_last), 64'd0);
        check_eq("mid_rst_overflow", 64'(overflow), 64'd0);
        check_idle("mid_rst");
        res_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            model_acc[i] = 48'd0;
        end
        step();
        rst_n = 1'b1;
        step();
        check_idle("after_rst");
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
